// File: rtl/bch_syndrome_trap.sv
// Serial syndrome generator and error-trapping sequencer for a 36-parity-bit
// cyclic code. It divides the received codeword by g(x) one bit per cycle.
// It then rotates the syndrome until the external weight checker flags a
// low-weight pattern, or until all N shifts have been examined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// COLLECT | accepting codeword bits, dividing by g(x)
// TRAP    | shifting the syndrome, sampling weight_flag each cycle
// DONE    | holding the trap result until out_ready
module bch_syndrome_trap #(
  parameter int          N     = 72,
  parameter logic [35:0] GPOLY = 36'h000000805
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_bit,
  output logic        in_ready,
  output logic [35:0] si,
  input  logic        weight_flag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        trap_ok,
  output logic [7:0]  trap_shift,
  output logic [35:0] trap_pattern
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    TRAP    = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [7:0] LAST = 8'(N - 1);

  state_t      state;
  logic [35:0] s;
  logic [7:0]  cnt;
  logic [7:0]  k;

  // One step of the divide-by-g(x) LFSR; the x^36 term of g is implicit.
  function automatic logic [35:0] lfsr_step(input logic [35:0] cur, input logic d);
    return {cur[34:0], d} ^ (cur[35] ? GPOLY : 36'h0);
  endfunction

  assign si = s;

  // Sequencer: the state register, the syndrome, the counters and the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= COLLECT;
      s            <= 36'h0;
      cnt          <= 8'h0;
      k            <= 8'h0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      trap_ok      <= 1'b0;
      trap_shift   <= 8'h0;
      trap_pattern <= 36'h0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_valid) begin
            s <= lfsr_step(s, in_bit);
            if (cnt == LAST) begin
              cnt      <= 8'h0;
              k        <= 8'h0;
              in_ready <= 1'b0;
              state    <= TRAP;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        TRAP: begin
          if (weight_flag) begin
            trap_ok      <= 1'b1;
            trap_shift   <= k;
            trap_pattern <= s;
            out_valid    <= 1'b1;
            state        <= DONE;
          end else if (k == LAST) begin
            // All N rotations examined without a low-weight pattern.
            trap_ok      <= 1'b0;
            trap_shift   <= LAST;
            trap_pattern <= 36'h0;
            out_valid    <= 1'b1;
            state        <= DONE;
          end else begin
            s <= lfsr_step(s, 1'b0);
            k <= k + 8'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            s         <= 36'h0;
            cnt       <= 8'h0;
            k         <= 8'h0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= COLLECT;
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bch_syndrome_trap.sv
// Self-checking bench for bch_syndrome_trap. The reference model computes the
// syndrome by polynomial long division over GF(2). Each shifted syndrome
// x^k * S(x) mod g(x) comes from the same long division.
module tb_bch_syndrome_trap;

  localparam int          N     = 72;
  localparam logic [35:0] GPOLY = 36'h000000805;
  localparam logic [36:0] GFULL = {1'b1, GPOLY};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_bit;
  logic        in_ready;
  logic [35:0] si;
  logic        weight_flag;
  logic        out_valid;
  logic        out_ready;
  logic        trap_ok;
  logic [7:0]  trap_shift;
  logic [35:0] trap_pattern;
  bit          force_zero;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Behavioural weight checker: popcount(si) <= 5, optionally forced low.
  assign weight_flag = force_zero ? 1'b0 : ($countones(si) <= 5);

  bch_syndrome_trap #(.N(N), .GPOLY(GPOLY)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready), .si(si), .weight_flag(weight_flag),
    .out_valid(out_valid), .out_ready(out_ready), .trap_ok(trap_ok),
    .trap_shift(trap_shift), .trap_pattern(trap_pattern)
  );

  typedef struct {
    string        name;
    logic [N-1:0] cw;
    bit           f0;
    bit           ok;
    logic [7:0]   sh;
    logic [35:0]  pat;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Remainder of v(x) mod g(x), found by long division.
  function automatic logic [35:0] poly_mod(input logic [511:0] v);
    logic [511:0] gw;
    gw = {475'b0, GFULL};
    for (int d = 511; d >= 36; d--)
      if (v[d]) v = v ^ (gw << (d - 36));
    return v[35:0];
  endfunction

  function automatic logic [35:0] syndrome_of(input logic [N-1:0] cw);
    return poly_mod({{(512-N){1'b0}}, cw});
  endfunction

  function automatic logic [35:0] shifted_syn(input logic [35:0] syn, input int kk);
    logic [511:0] v;
    v = {476'b0, syn};
    return poly_mod(v << kk);
  endfunction

  task automatic ref_trap(input logic [N-1:0] cw, input bit f0,
                          output bit ok, output logic [7:0] sh, output logic [35:0] pat);
    logic [35:0] syn, sk;
    syn = syndrome_of(cw);
    ok  = 1'b0;
    sh  = 8'(N - 1);
    pat = 36'h0;
    if (!f0) begin
      for (int kk = 0; kk < N; kk++) begin
        sk = shifted_syn(syn, kk);
        if ($countones(sk) <= 5) begin
          ok  = 1'b1;
          sh  = 8'(kk);
          pat = sk;
          break;
        end
      end
    end
  endtask

  task automatic send_bits(input logic [N-1:0] cw, input int nbits, input bit gaps);
    for (int i = 0; i < nbits; i++) begin
      if (gaps) begin
        while ($urandom_range(3) == 0) begin
          in_valid = 1'b0;
          in_bit   = 1'($urandom);
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_bit   = cw[N-1-i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  // Sends a codeword, measures the latency from the last accept to out_valid,
  // and checks the result. The result is left pending in DONE.
  task automatic run_vec(input string nm, input logic [N-1:0] cw, input bit f0,
                         input bit ok, input logic [7:0] sh, input logic [35:0] pat,
                         input bit gaps);
    int lat;
    force_zero = f0;
    send_bits(cw, N, gaps);
    lat = 0;
    while (!out_valid && lat < N + 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, ".latency"}, 64'(lat), 64'(int'(sh) + 1));
    check({nm, ".trap_ok"}, 64'(trap_ok), 64'(ok));
    check({nm, ".trap_shift"}, 64'(trap_shift), 64'(sh));
    check({nm, ".trap_pattern"}, 64'(trap_pattern), 64'(pat));
    if (ok) check({nm, ".si_held"}, 64'(si), 64'(pat));
  endtask

  task automatic consume(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, ".in_ready_after"}, 64'(in_ready), 64'd1);
    check({nm, ".out_valid_after"}, 64'(out_valid), 64'd0);
    check({nm, ".si_cleared"}, 64'(si), 64'd0);
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, ".in_ready"}, 64'(in_ready), 64'd1);
    check({nm, ".out_valid"}, 64'(out_valid), 64'd0);
    check({nm, ".trap_ok"}, 64'(trap_ok), 64'd0);
    check({nm, ".trap_shift"}, 64'(trap_shift), 64'd0);
    check({nm, ".trap_pattern"}, 64'(trap_pattern), 64'd0);
    check({nm, ".si"}, 64'(si), 64'd0);
  endtask

  function automatic logic [N-1:0] rand_word();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[N-1:0];
  endfunction

  // Valid codeword (systematic encoding) plus a few random bit errors.
  function automatic logic [N-1:0] rand_codeword_with_errors(input int nerr);
    logic [N-1:0] w, m;
    m = rand_word();
    m = (m >> 36) << 36;
    w = m | N'(syndrome_of(m));
    for (int e = 0; e < nerr; e++) w[$urandom_range(N-1)] = ~w[$urandom_range(N-1)];
    return w;
  endfunction

  vec_t vecs[4];

  initial begin
    logic [N-1:0] cw;
    bit           ok;
    logic [7:0]   sh;
    logic [35:0]  pat;
    logic [35:0]  syn;

    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0; force_zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    rst = 1'b0;

    // Directed vectors.
    vecs[0] = '{"all_zero", '0, 1'b0, 1'b1, 8'd0, 36'h0};
    cw = '0; cw[0] = 1'b1;
    vecs[1] = '{"last_bit_one", cw, 1'b0, 1'b1, 8'd0, 36'h000000001};
    cw = '0; cw[N-1] = 1'b1;
    ref_trap(cw, 1'b0, ok, sh, pat);
    vecs[2] = '{"single_err_pos0", cw, 1'b0, ok, sh, pat};
    vecs[3] = '{"forced_no_trap", rand_word(), 1'b1, 1'b0, 8'(N - 1), 36'h0};

    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i].name, vecs[i].cw, vecs[i].f0, vecs[i].ok, vecs[i].sh, vecs[i].pat, 1'b0);
      consume(vecs[i].name);
    end

    // Backpressure in DONE with in_valid toggling.
    cw = rand_codeword_with_errors(2);
    ref_trap(cw, 1'b0, ok, sh, pat);
    run_vec("bp", cw, 1'b0, ok, sh, pat, 1'b0);
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      in_bit   = 1'b1;
      @(posedge clk); #1;
      check("bp.in_ready", 64'(in_ready), 64'd0);
      check("bp.out_valid", 64'(out_valid), 64'd1);
      check("bp.trap_state", {19'b0, trap_ok, trap_shift, trap_pattern}, {19'b0, ok, sh, pat});
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
    consume("bp");

    // Reset mid-TRAP at k = 5.
    cw = rand_word();
    syn = syndrome_of(cw);
    force_zero = 1'b1;
    send_bits(cw, N, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    check("rst_trap.si_at_k5", 64'(si), 64'(shifted_syn(syn, 5)));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    force_zero = 1'b0;
    check_reset_vals("rst_trap");
    cw = rand_codeword_with_errors(3);
    ref_trap(cw, 1'b0, ok, sh, pat);
    run_vec("after_rst_trap", cw, 1'b0, ok, sh, pat, 1'b0);
    consume("after_rst_trap");

    // Reset mid-COLLECT at cnt = 30.
    send_bits(rand_word(), 30, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_vals("rst_collect");
    cw = rand_codeword_with_errors(1);
    ref_trap(cw, 1'b0, ok, sh, pat);
    run_vec("after_rst_collect", cw, 1'b0, ok, sh, pat, 1'b0);
    consume("after_rst_collect");

    // Randomized codewords with input gaps against the reference model.
    for (int t = 0; t < 40; t++) begin
      if (t % 4 == 3) cw = rand_word();
      else            cw = rand_codeword_with_errors($urandom_range(1, 5));
      ref_trap(cw, 1'b0, ok, sh, pat);
      run_vec($sformatf("rand%0d", t), cw, 1'b0, ok, sh, pat, 1'b1);
      consume($sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bch_syndrome_trap.md
# bch_syndrome_trap

Serial syndrome generator and error-trapping sequencer for the 36-parity-bit cyclic code used in the QR decode path. It accepts a received codeword one bit per cycle and divides it by the generator polynomial to form a 36-bit syndrome. It then cyclically shifts the syndrome, presenting each shift on `si` to the downstream weight-≤5 checker and sampling the checker's `weight_flag` return. The trap result (found/not found, shift count, trapped pattern) goes to the correction stage over a valid/ready handshake.

## Interface
- N, 72: codeword length in bits. Legal range 37..255.
- GPOLY, 36'h000000805: coefficients x^35..x^0 of g(x). The x^36 term is implicit.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  `in_bit` is valid this cycle.
- in_bit  input  1  codeword bit, highest-degree coefficient first.
- in_ready  output  1  block accepts a bit this cycle.
- si  output  36  current syndrome register, driven to the weight checker.
- weight_flag  input  1  checker result for `si`: 1 when popcount(`si`) ≤ 5. Combinational from `si`, same cycle.
- out_valid  output  1  result held on `trap_*`.
- out_ready  input  1  downstream accepts the result.
- trap_ok  output  1  1 = trap found.
- trap_shift  output  8  number of shifts k at which the trap occurred.
- trap_pattern  output  36  syndrome value at shift k.

## Operation
- State machine: COLLECT → TRAP → DONE → COLLECT.
- Registers:
  - S[35:0]: syndrome register; `si` = S in every state.
  - cnt[7:0]: bit counter.
  - k[7:0]: shift counter.
- LFSR step, shared by both phases: S_next = {S[34:0], d} ^ (S[35] ? GPOLY : 36'h0).
  - COLLECT: d = `in_bit`.
  - TRAP: d = 0.
- COLLECT:
  - `in_ready` = 1.
  - On `in_valid`, apply the LFSR step with d = `in_bit` and increment cnt.
  - On accepting bit number N (cnt == N-1): go to TRAP with k = 0 and cnt = 0.
- TRAP:
  - `in_ready` = 0. `weight_flag` is sampled every cycle.
  - If `weight_flag` = 1: latch trap_ok = 1, trap_shift = k, trap_pattern = S, then go to DONE.
  - Else if k == N-1: latch trap_ok = 0, trap_shift = N-1, trap_pattern = 0, then go to DONE.
  - Else: apply the LFSR step with d = 0 and increment k.
  - At most N syndrome values (k = 0..N-1) are examined.
- DONE:
  - `out_valid` = 1. `trap_*` and S are held stable.
  - On `out_ready`: go to COLLECT next cycle with S = 0, cnt = 0, k = 0.
- `weight_flag` is ignored outside TRAP.
- `in_valid` is ignored outside COLLECT; bits offered then are not consumed.

## Timing
- Reset values: state = COLLECT; S = 0; cnt = 0; k = 0. Outputs: `in_ready` = 1, `out_valid` = 0, `trap_ok` = 0, `trap_shift` = 0, `trap_pattern` = 0, `si` = 0.
- A reset asserted in any state, including mid-COLLECT or mid-TRAP, abandons the codeword. The reset values apply on the following cycle.
- Throughput in COLLECT: 1 bit per cycle. Gaps in `in_valid` stall without side effect.
- Latency, with the last bit accepted at edge E0:
  - TRAP with k = 0 is active in the cycle after E0.
  - A trap at shift k is registered at edge E0+k+1.
  - `out_valid` is high from cycle E0+k+1 onward.
  - No trap: `out_valid` goes high at E0+N.
- `out_valid` and `out_ready` high together: the result is consumed that edge. `in_ready` = 1 in the next cycle. There is no overlap between result hold and new bit collection.
- `out_valid` stays asserted, with all outputs constant, until `out_ready`.
- Trap decision on the boundary shift k = N-1: if `weight_flag` = 1 there, it is a trap (trap_ok = 1), not a failure.

## Test plan
- All-zero codeword (N = 72 zeros) → S = 0, `weight_flag` = 1 at k = 0 → `out_valid` in the cycle after the last bit accept; trap_ok = 1, trap_shift = 0, trap_pattern = 0.
- Codeword zeros except the final bit = 1 → S = 36'h000000001, trap at k = 0, trap_pattern = 36'h000000001.
- Single error at stream position 0 (degree N-1) → trap_ok = 1. trap_shift and trap_pattern must match a bit-accurate software model of the LFSR plus popcount.
- Checker output forced to 0 → `out_valid` exactly N cycles after the last accept; trap_ok = 0, trap_shift = 71, trap_pattern = 0.
- Backpressure: `out_ready` low for 10 cycles in DONE with `in_valid` toggling → `trap_*` stable, `in_ready` = 0, no bits consumed. Raise `out_ready` → `in_ready` = 1 the next cycle.
- Reset: assert `rst` at k = 5 in TRAP, and separately at cnt = 30 in COLLECT → next cycle all outputs at reset values. A full codeword sent afterwards decodes correctly.
